gpu_op_arbiter: RTL and testbench

GPU_OP_ARBITER -- requirements
Module: gpu_op_arbiter

---
 rtl/gpu_op_arbiter.sv | 130 +++++++++++++
 tb/tb_gpu_op_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_op_arbiter.sv
// gpu_op_arbiter: round-robin arbiter that shares one GPU op port among
// REQ_COUNT draw requesters. A grant is issued only while the GPU reports
// idle (op_ready=1); after each issue the block spends one cycle ignoring
// op_ready (the GPU needs that long to lower it) and then waits for
// op_ready to rise again before the next grant.
//
// Ports:
//   clk        - single clock, all logic on posedge
//   rst        - synchronous active-high reset, honoured regardless of ce
//   ce         - clock enable; no register changes while low
//   req_op     - one gpu_op_t per requester
//   req_valid  - per-requester level request
//   req_ready  - per-requester accept pulse (one-hot or zero)
//   op         - op presented to the GPU, stable until the next grant
//   op_valid   - issue pulse to the GPU
//   op_ready   - GPU idle level
//   grant_idx  - index of the most recently granted requester
//   busy       - high whenever the FSM is not in IDLE

package gpu_op_pkg;
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] width;
    logic [10:0] height;
    logic        color;
    logic        mem_en;
    logic [10:0] mem_addr;
    logic [2:0]  scale;
  } gpu_op_t;
endpackage

module gpu_op_arbiter
  import gpu_op_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  parameter int IDX_W     = $clog2(REQ_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  gpu_op_t [REQ_COUNT-1:0]  req_op,
  input  logic    [REQ_COUNT-1:0]  req_valid,
  output logic    [REQ_COUNT-1:0]  req_ready,
  output gpu_op_t                  op,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic    [IDX_W-1:0]      grant_idx,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    WAIT_OP_READY_1 = 2'd1,
    WAIT_OP_READY_2 = 2'd2
  } state_t;

  state_t               state;
  logic                 found;
  logic [IDX_W-1:0]     pick;
  logic [IDX_W-1:0]     cand;
  logic [REQ_COUNT-1:0] one_lsb;

  assign one_lsb = {{(REQ_COUNT-1){1'b0}}, 1'b1};
  assign busy    = (state != IDLE);

  // Round-robin search starting just after the last grant. Starting the
  // search at grant_idx+1 is what pushes a requester that keeps req_valid
  // high behind every other pending requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= REQ_COUNT; k++) begin
      cand = IDX_W'((int'(grant_idx) + k) % REQ_COUNT);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Grant FSM. Reset is checked ahead of ce so an abandoned transaction is
  // cleared even while the enable is low. grant_idx resets to the last
  // requester so that requester 0 is the first one searched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      op_valid  <= 1'b0;
      req_ready <= '0;
      grant_idx <= IDX_W'(REQ_COUNT - 1);
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (op_ready && found) begin
            op        <= req_op[pick];
            op_valid  <= 1'b1;
            req_ready <= one_lsb << pick;
            grant_idx <= pick;
            state     <= WAIT_OP_READY_1;
          end else begin
            op_valid  <= 1'b0;
            req_ready <= '0;
          end
        end
        // op_ready may still show the pre-issue idle level here, so it is
        // deliberately not looked at.
        WAIT_OP_READY_1: begin
          op_valid  <= 1'b0;
          req_ready <= '0;
          state     <= WAIT_OP_READY_2;
        end
        WAIT_OP_READY_2: begin
          op_valid  <= 1'b0;
          req_ready <= '0;
          if (op_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          op_valid  <= 1'b0;
          req_ready <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// tb_gpu_op_arbiter: directed bench for gpu_op_arbiter (REQ_COUNT=4).
// Each scenario pushes its hand-computed grants (index + op) into a
// scoreboard queue before driving the requests; a separate monitor pops an
// entry on every rising op_valid and compares grant_idx, op and req_ready.
// Ports exercised: every DUT port; a small GPU model optionally drives
// op_ready low for two cycles after each issue.

module tb_gpu_op_arbiter;
  import gpu_op_pkg::*;

  typedef struct packed {
    logic [1:0] idx;
    gpu_op_t    op;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               ce;
  gpu_op_t [3:0]      req_op;
  logic    [3:0]      req_valid;
  logic    [3:0]      req_ready;
  gpu_op_t            op;
  logic               op_valid;
  logic               op_ready;
  logic    [1:0]      grant_idx;
  logic               busy;

  gpu_op_t tab [4];
  exp_t    sb[$];
  int      total = 0;
  int      bad = 0;
  int      issue_cnt = 0;
  int      onehot_err = 0;
  int      rr1_cnt = 0;
  bit      mon_en = 1'b0;
  bit      mon_prev = 1'b0;
  bit      gpu_auto = 1'b0;
  bit      gpu_prev = 1'b0;
  int      gpu_cnt = 0;

  gpu_op_arbiter #(.REQ_COUNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req_op    (req_op),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic ordy, input logic cev, input logic rstv);
    req_valid = rv;
    op_ready  = ordy;
    ce        = cev;
    rst       = rstv;
  endtask

  // Advance to just after the next falling edge, after the monitor has run.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic expectGrant(input int i);
    exp_t e;
    e.idx = 2'(i);
    e.op  = tab[i];
    sb.push_back(e);
  endtask

  task automatic waitIssues(input int target, input int budget);
    int n;
    n = 0;
    while (issue_cnt < target && n < budget) begin
      cyc();
      n++;
    end
    checkOutput("issue_count", 64'(issue_cnt), 64'(target));
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      cyc();
      n++;
    end
    checkOutput("reach_idle", 64'(busy), 64'd0);
  endtask

  // Scoreboard monitor: one pop per rising op_valid, so a pulse stretched
  // by ce=0 is checked once.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (op_valid === 1'b1 && !mon_prev) begin
        issue_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_issue: got grant_idx=%0d, want no issue", grant_idx);
        end else begin
          e = sb.pop_front();
          checkOutput("grant_idx", 64'(grant_idx), 64'(e.idx));
          checkOutput("op", 64'(op), 64'(e.op));
          checkOutput("req_ready", 64'(req_ready), 64'(4'b0001 << e.idx));
        end
      end
      if (!$onehot0(req_ready)) onehot_err++;
      if (req_ready[1] === 1'b1) rr1_cnt++;
      mon_prev = (op_valid === 1'b1);
    end
  end

  // GPU model: drops op_ready on an issue and raises it two cycles later.
  always @(negedge clk) begin
    if (gpu_auto) begin
      if (op_valid === 1'b1 && !gpu_prev) begin
        op_ready = 1'b0;
        gpu_cnt  = 2;
      end else if (gpu_cnt > 0) begin
        gpu_cnt--;
        if (gpu_cnt == 0) op_ready = 1'b1;
      end
    end
    gpu_prev = (op_valid === 1'b1);
  end

  initial begin
    int base;
    tab[0] = '{x:11'd10,  y:11'd20,  width:11'd64,  height:11'd32,  color:1'b1, mem_en:1'b0, mem_addr:11'd0,    scale:3'd1};
    tab[1] = '{x:11'd100, y:11'd200, width:11'd16,  height:11'd16,  color:1'b0, mem_en:1'b1, mem_addr:11'd1234, scale:3'd2};
    tab[2] = '{x:11'd2047,y:11'd1,   width:11'd1,   height:11'd2047,color:1'b1, mem_en:1'b1, mem_addr:11'd2047, scale:3'd7};
    tab[3] = '{x:11'd555, y:11'd777, width:11'd300, height:11'd5,   color:1'b0, mem_en:1'b0, mem_addr:11'd42,   scale:3'd4};
    for (int i = 0; i < 4; i++) req_op[i] = tab[i];

    // Reset with ce low: reset must still take effect.
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    cyc();
    cyc();
    checkOutput("rst_op", 64'(op), 64'd0);
    checkOutput("rst_op_valid", 64'(op_valid), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_grant_idx", 64'(grant_idx), 64'd3);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    mon_en = 1'b1;

    // All four requesting, GPU model active: 0,1,2,3,0.
    base = issue_cnt;
    gpu_auto = 1'b1;
    expectGrant(0); expectGrant(1); expectGrant(2); expectGrant(3); expectGrant(0);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    waitIssues(base + 5, 60);
    req_valid = 4'b0000;
    waitIdle(20);

    // Wrap-around: grant 3, then 1001 gives 0 then 3.
    base = issue_cnt;
    expectGrant(3);
    req_valid = 4'b1000;
    waitIssues(base + 1, 20);
    expectGrant(0); expectGrant(3);
    req_valid = 4'b1001;
    waitIssues(base + 3, 30);
    req_valid = 4'b0000;
    waitIdle(20);

    // op_ready low for 10 cycles: nothing issued, block stays idle.
    gpu_auto = 1'b0;
    applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      checkOutput("hold_busy", 64'(busy), 64'd0);
      checkOutput("hold_op_valid", 64'(op_valid), 64'd0);
    end
    expectGrant(2);
    op_ready = 1'b1;
    cyc();
    checkOutput("latency_op_valid", 64'(op_valid), 64'd1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    cyc();
    cyc();
    op_ready = 1'b1;
    waitIdle(10);

    // ce pattern 1,0,0,1 around an issue.
    expectGrant(0);
    applyStimulus(4'b0001, 1'b1, 1'b1, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      checkOutput("ce0_op_valid", 64'(op_valid), 64'd1);
      checkOutput("ce0_req_ready", 64'(req_ready), 64'h1);
      checkOutput("ce0_busy", 64'(busy), 64'd1);
    end
    ce = 1'b1;
    cyc();
    checkOutput("ce1_op_valid", 64'(op_valid), 64'd0);
    checkOutput("ce1_busy", 64'(busy), 64'd1);
    ce = 1'b0;
    cyc();
    checkOutput("ce0_w2_busy", 64'(busy), 64'd1);
    ce = 1'b1;
    cyc();
    checkOutput("ce1_idle_busy", 64'(busy), 64'd0);

    // Reset while waiting in WAIT_OP_READY_2.
    expectGrant(1);
    applyStimulus(4'b0010, 1'b1, 1'b1, 1'b0);
    cyc();
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0);
    cyc();
    cyc();
    checkOutput("w2_busy", 64'(busy), 64'd1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1);
    cyc();
    checkOutput("mid_rst_op", 64'(op), 64'd0);
    checkOutput("mid_rst_op_valid", 64'(op_valid), 64'd0);
    checkOutput("mid_rst_grant_idx", 64'(grant_idx), 64'd3);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    expectGrant(0);
    rst = 1'b0;
    cyc();
    req_valid = 4'b0000;
    waitIdle(10);

    // Requester 1 withdraws just before its turn; 2 is granted instead.
    rr1_cnt = 0;
    applyStimulus(4'b1110, 1'b0, 1'b1, 1'b0);
    cyc();
    cyc();
    checkOutput("withdraw_busy", 64'(busy), 64'd0);
    expectGrant(2);
    applyStimulus(4'b1100, 1'b1, 1'b1, 1'b0);
    cyc();
    req_valid = 4'b0000;
    waitIdle(10);
    cyc();
    checkOutput("rr1_pulses", 64'(rr1_cnt), 64'd0);

    checkOutput("scoreboard_left", 64'(sb.size()), 64'd0);
    checkOutput("req_ready_onehot", 64'(onehot_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
